// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: shared state encoding, default sizing and JTAG pin reset levels
package jtag_master_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_MAX_BITS = 32;
  localparam logic TCK_RST = 1'b0;
  localparam logic TMS_RST = 1'b1;
  localparam logic TDI_RST = 1'b0;
endpackage

// File: rtl/jtag_master_tick.sv
// jtag_master_tick: counts CLK_DIV cycles per TCK half-period, reloading at every phase end
module jtag_master_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic restart,
  output logic phase_done
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] cnt;
  assign phase_done = en && cnt == LAST;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= (restart || phase_done || !en) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/jtag_master.sv
// jtag_master: shifts LSB-first TMS/TDI vectors through a TAP and returns the captured TDO bits
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int MAX_BITS = DEF_MAX_BITS,
  parameter int LEN_W = $clog2(MAX_BITS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [MAX_BITS-1:0] cmd_tms_i,
  input  logic [MAX_BITS-1:0] cmd_tdi_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [MAX_BITS-1:0] rsp_tdo_o,
  output logic                jtag_tck_o,
  output logic                jtag_tms_o,
  output logic                jtag_tdi_o,
  output logic                jtag_trst_no,
  input  logic                jtag_tdo_i
);
  localparam int IW = MAX_BITS > 1 ? $clog2(MAX_BITS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);
  state_t state;
  logic [LEN_W-1:0] len_q, sat_len;
  logic [IW-1:0] idx;
  logic [MAX_BITS-1:0] tms_sr, tdi_sr, shadow;
  logic accept, phase_done;
  assign accept = state == IDLE && cmd_valid_i && cmd_ready_o;
  assign sat_len = cmd_len_i > MAX_LEN ? MAX_LEN : cmd_len_i;
  jtag_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en(state == LOW || state == HIGH),
    .restart(accept),
    .phase_done(phase_done)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      jtag_tck_o <= TCK_RST;
      jtag_tms_o <= TMS_RST;
      jtag_tdi_o <= TDI_RST;
      jtag_trst_no <= 1'b0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_tdo_o <= '0;
      len_q <= '0;
      idx <= '0;
      tms_sr <= '0;
      tdi_sr <= '0;
      shadow <= '0;
    end else begin
      jtag_trst_no <= 1'b1;
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            cmd_ready_o <= 1'b0;
            len_q <= sat_len;
            idx <= '0;
            shadow <= '0;
            tms_sr <= cmd_tms_i >> 1;
            tdi_sr <= cmd_tdi_i >> 1;
            if (cmd_len_i == '0) begin
              state <= RESP;
              rsp_tdo_o <= '0;
            end else begin
              state <= LOW;
              jtag_tms_o <= cmd_tms_i[0];
              jtag_tdi_o <= cmd_tdi_i[0];
            end
          end
        end
        LOW:
          if (phase_done) begin
            jtag_tck_o <= 1'b1;
            shadow[idx] <= jtag_tdo_i;
            state <= HIGH;
          end
        HIGH:
          if (phase_done) begin
            jtag_tck_o <= 1'b0;
            if (LEN_W'(idx) == len_q - 1'b1) begin
              state <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_tdo_o <= shadow;
            end else begin
              idx <= idx + 1'b1;
              jtag_tms_o <= tms_sr[0];
              jtag_tdi_o <= tdi_sr[0];
              tms_sr <= tms_sr >> 1;
              tdi_sr <= tdi_sr >> 1;
              state <= LOW;
            end
          end
        RESP:
          if (!rsp_valid_o) rsp_valid_o <= 1'b1;
          else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: cycle-level waveform model plus directed JTAG command vectors
module tb_jtag_master;
  localparam int D = 2;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o;
  logic [5:0] cmd_len_i = '0;
  logic [31:0] cmd_tms_i = '0, cmd_tdi_i = '0, rsp_tdo_o;
  logic rsp_valid_o, rsp_ready_i = 1'b0;
  logic jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, jtag_tdo_i;
  logic loop = 1'b0;
  int n_tests = 0, n_fail = 0, rises = 0;
  assign jtag_tdo_i = loop ? jtag_tdi_o : 1'b0;

  jtag_master #(.CLK_DIV(D), .MAX_BITS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .cmd_tms_i(cmd_tms_i), .cmd_tdi_i(cmd_tdi_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tdo_o(rsp_tdo_o),
    .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
    .jtag_trst_no(jtag_trst_no), .jtag_tdo_i(jtag_tdo_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_pins(input string nm);
    chkb({nm, "_tck"}, jtag_tck_o, 1'b0);
    chkb({nm, "_tms"}, jtag_tms_o, 1'b1);
    chkb({nm, "_tdi"}, jtag_tdi_o, 1'b0);
    chkb({nm, "_trst"}, jtag_trst_no, 1'b0);
    chkb({nm, "_ready"}, cmd_ready_o, 1'b0);
    chkb({nm, "_rspv"}, rsp_valid_o, 1'b0);
    chk({nm, "_tdo"}, rsp_tdo_o, 32'h0);
  endtask

  // model: after accept, cycle k of a len-L command is bit k/(2D), TCK high in its second half
  logic m_fresh = 1'b1, m_busy = 1'b0, m_loop = 1'b0;
  int m_k = 0, m_len = 0;
  logic [31:0] m_tms = '0, m_tdi = '0;
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0;

  always @(negedge clk_i) begin
    int lat, b;
    logic [63:0] one, mask;
    one = 64'd1;
    if (rst_i) begin
      chk_reset_pins("m_rst");
      m_fresh = 1'b1;
      m_busy = 1'b0;
    end else if (m_fresh) begin
      chk_reset_pins("m_fresh");
      m_fresh = 1'b0;
    end else if (!m_busy) begin
      chkb("m_idle_ready", cmd_ready_o, 1'b1);
      chkb("m_idle_rspv", rsp_valid_o, 1'b0);
      chkb("m_idle_tck", jtag_tck_o, 1'b0);
      chkb("m_idle_trst", jtag_trst_no, 1'b1);
      if (cmd_valid_i) begin
        m_busy = 1'b1;
        m_k = 0;
        m_len = int'(cmd_len_i) > 32 ? 32 : int'(cmd_len_i);
        m_tms = cmd_tms_i;
        m_tdi = cmd_tdi_i;
        m_loop = loop;
      end
    end else begin
      lat = m_len == 0 ? 1 : 2 * D * m_len;
      chkb("m_busy_ready", cmd_ready_o, 1'b0);
      chkb("m_busy_trst", jtag_trst_no, 1'b1);
      if (m_k < lat) begin
        chkb("m_shift_rspv", rsp_valid_o, 1'b0);
        if (m_len > 0) begin
          b = m_k / (2 * D);
          chkb("m_shift_tck", jtag_tck_o, (m_k % (2 * D)) >= D);
          chkb("m_shift_tms", jtag_tms_o, m_tms[b[4:0]]);
          chkb("m_shift_tdi", jtag_tdi_o, m_tdi[b[4:0]]);
        end else chkb("m_zero_tck", jtag_tck_o, 1'b0);
      end else begin
        mask = (one << m_len) - 64'd1;
        chkb("m_rsp_rspv", rsp_valid_o, 1'b1);
        chk("m_rsp_tdo", rsp_tdo_o, m_loop ? m_tdi & mask[31:0] : 32'h0);
        chkb("m_rsp_tck", jtag_tck_o, 1'b0);
        if (m_len > 0) begin
          b = m_len - 1;
          chkb("m_rsp_tms", jtag_tms_o, m_tms[b[4:0]]);
          chkb("m_rsp_tdi", jtag_tdi_o, m_tdi[b[4:0]]);
        end
      end
      if (m_k >= lat && rsp_ready_i) m_busy = 1'b0;
      else m_k++;
    end
    if (!rst_i && p_tck && jtag_tck_o) begin
      chkb("tms_stable_high", jtag_tms_o, p_tms);
      chkb("tdi_stable_high", jtag_tdi_o, p_tdi);
    end
    if (jtag_tck_o && !p_tck) rises++;
    p_tck = jtag_tck_o;
    p_tms = jtag_tms_o;
    p_tdi = jtag_tdi_o;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_cmd(input int len, input logic [31:0] tms, input logic [31:0] tdi,
                        input int hold, output logic [31:0] tdo, output int lat, output int pulses);
    int n, r0;
    logic [31:0] held;
    step();
    cmd_valid_i = 1'b1;
    cmd_len_i = 6'(len);
    cmd_tms_i = tms;
    cmd_tdi_i = tdi;
    rsp_ready_i = 1'b0;
    n = 0;
    while (!cmd_ready_o && n < 100) begin step(); n++; end
    if (n >= 100) chkb("accept_timeout", 1'b0, 1'b1);
    r0 = rises;
    step();
    cmd_valid_i = 1'b0;
    lat = 0;
    while (!rsp_valid_o && lat < 400) begin step(); lat++; end
    if (lat >= 400) chkb("rsp_timeout", 1'b0, 1'b1);
    tdo = rsp_tdo_o;
    held = rsp_tdo_o;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_tdo_stable", rsp_tdo_o, held);
      chkb("bp_rspv", rsp_valid_o, 1'b1);
      chkb("bp_ready", cmd_ready_o, 1'b0);
      chkb("bp_tck", jtag_tck_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    pulses = rises - r0;
    chkb("post_hs_ready", cmd_ready_o, 1'b1);
    chkb("post_hs_rspv", rsp_valid_o, 1'b0);
  endtask

  initial begin
    logic [31:0] tdo;
    int lat, pulses, n, r0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_pins("lit_reset");
    rst_i = 1'b0;
    step();
    chkb("lit_trst_up", jtag_trst_no, 1'b1);
    chkb("lit_ready_up", cmd_ready_o, 1'b1);

    loop = 1'b0;
    do_cmd(5, 32'h1F, 32'h0, 0, tdo, lat, pulses);
    chk("tlr_lat", 32'(lat), 32'd20);
    chk("tlr_tdo", tdo, 32'h0);
    chk("tlr_pulses", 32'(pulses), 32'd5);

    loop = 1'b1;
    do_cmd(8, 32'h0, 32'hA5, 0, tdo, lat, pulses);
    chk("lb8_tdo", tdo, 32'h000000A5);
    chk("lb8_lat", 32'(lat), 32'd32);
    do_cmd(32, 32'h0, 32'hDEADBEEF, 0, tdo, lat, pulses);
    chk("lb32_tdo", tdo, 32'hDEADBEEF);

    do_cmd(6, 32'h15, 32'h3C, 10, tdo, lat, pulses);
    chk("bp_tdo", tdo, 32'h0000003C);

    do_cmd(0, 32'h0, 32'hFF, 0, tdo, lat, pulses);
    chk("len0_lat", 32'(lat), 32'd1);
    chk("len0_tdo", tdo, 32'h0);
    chk("len0_pulses", 32'(pulses), 32'd0);
    do_cmd(40, 32'h0, 32'h12345678, 0, tdo, lat, pulses);
    chk("sat_pulses", 32'(pulses), 32'd32);
    chk("sat_lat", 32'(lat), 32'd128);
    chk("sat_tdo", tdo, 32'h12345678);

    step();
    cmd_valid_i = 1'b1;
    cmd_len_i = 6'd16;
    cmd_tms_i = 32'h0;
    cmd_tdi_i = 32'hFFFF;
    n = 0;
    while (!cmd_ready_o && n < 100) begin step(); n++; end
    r0 = rises;
    step();
    cmd_valid_i = 1'b0;
    n = 0;
    while (rises - r0 < 3 && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) chkb("rst_wait_timeout", 1'b0, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk_reset_pins("lit_midrst");
    repeat (2) step();
    rst_i = 1'b0;
    chkb("midrst_no_rsp", rsp_valid_o, 1'b0);
    do_cmd(4, 32'h0, 32'h9, 0, tdo, lat, pulses);
    chk("after_rst_tdo", tdo, 32'h9);

    step();
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_len_i = 6'd4;
    cmd_tdi_i = 32'h3;
    n = 0;
    while (cmd_ready_o && n < 100) begin step(); n++; end
    cmd_len_i = 6'd3;
    cmd_tdi_i = 32'h5;
    n = 0;
    while (!rsp_valid_o && n < 100) begin step(); n++; end
    chk("b2b_a_tdo", rsp_tdo_o, 32'h3);
    step();
    chkb("b2b_hs_ready", cmd_ready_o, 1'b1);
    step();
    chkb("b2b_b_accepted", cmd_ready_o, 1'b0);
    cmd_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 100) begin step(); n++; end
    chk("b2b_b_tdo", rsp_tdo_o, 32'h5);
    step();
    rsp_ready_i = 1'b0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
